// File: rtl/atp_pkg.sv
// Shared encodings for the ATP session sequencer: state and error codes,
// amount width and a small state-classification helper.
package atp_pkg;

  localparam int AMT_W = 11;

  typedef enum logic [2:0] {
    S_INPUT    = 3'b000,
    S_VALIDATE = 3'b001,
    S_BILL     = 3'b010,
    S_CHARGES  = 3'b011,
    S_METHOD   = 3'b100,
    S_OLDBAL   = 3'b101,
    S_TXN      = 3'b110,
    S_RECEIPT  = 3'b111
  } state_e;

  typedef enum logic [2:0] {
    E_NONE       = 3'b000,
    E_BAD_AUTH   = 3'b001,
    E_BAD_AMOUNT = 3'b010,
    E_OVERFLOW   = 3'b011,
    E_TXN_FAIL   = 3'b100,
    E_TIMEOUT    = 3'b101
  } err_e;

  // States that wait on an external ack and are guarded by the timeout counter
  function automatic logic is_timed(state_e s);
    return (s == S_VALIDATE) || (s == S_TXN);
  endfunction

endpackage

// File: rtl/atp_timeout_ctr.sv
// Ack-wait watchdog: reloads on every state change, counts down while the
// sequencer sits in a timed state, flags expiry on the last allowed cycle.
module atp_timeout_ctr #(
  parameter logic [7:0] LOAD_VAL = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  // Down-counter; holds at zero so it never wraps outside a timed state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= 8'd0;
    else if (load)               cnt <= LOAD_VAL;
    else if (en && cnt != 8'd0)  cnt <= cnt - 8'd1;
  end

  // cnt==1 means this is the LOAD_VAL-th cycle spent waiting
  assign expired = en && (cnt == 8'd1);

endmodule

// File: rtl/atp_session_ctrl.sv
// Session sequencer: walks one customer from id entry through lookup,
// amount/method entry, charges, balance and ledger debit to receipt.
module atp_session_ctrl
  import atp_pkg::*;
#(
  parameter int               MAX_RETRIES    = 3,
  parameter logic [AMT_W-1:0] CHEQUE_FEE     = 11'd10,
  parameter int               TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             exit,
  input  logic [11:0]      phone_number,
  input  logic [7:0]       auth_hash,
  output logic             lookup_req,
  input  logic             lookup_ack,
  input  logic             lookup_found,
  input  logic [7:0]       lookup_hash,
  input  logic [AMT_W-1:0] lookup_bill,
  input  logic [AMT_W-1:0] amount,
  input  logic             amount_valid,
  input  logic             pay_method,
  input  logic             method_valid,
  output logic [AMT_W-1:0] charges,
  output logic             txn_req,
  output logic [AMT_W-1:0] txn_amount,
  input  logic             txn_ack,
  input  logic             txn_ok,
  output logic [AMT_W-1:0] bill_amount,
  output logic [AMT_W-1:0] new_balance,
  output logic             receipt_valid,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [2:0]       state,
  output logic             locked
);

  state_e           state_q, nxt;
  logic [11:0]      phone_q;
  logic [7:0]       hash_q;
  logic [AMT_W-1:0] amt_q;
  logic             pm_q;
  logic [2:0]       fail_cnt;
  logic [2:0]       fail_inc;
  logic [AMT_W:0]   total;
  logic             expired;

  logic   err_fire;
  err_e   err_val;
  logic   latch_start, latch_amt, latch_pm, latch_chg, latch_bal;
  logic   auth_ok, auth_fail, clr_lock;

  assign total    = {1'b0, amt_q} + {1'b0, (pm_q ? CHEQUE_FEE : {AMT_W{1'b0}})};
  assign fail_inc = fail_cnt + 3'd1;

  atp_timeout_ctr #(.LOAD_VAL(8'(TIMEOUT_CYCLES))) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .load    (nxt != state_q),
    .en      (is_timed(state_q)),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INPUT;
    else     state_q <= nxt;
  end

  // Next-state and per-cycle control strobes; exit beats acks except in TXN
  always_comb begin
    nxt         = state_q;
    err_fire    = 1'b0;
    err_val     = E_NONE;
    latch_start = 1'b0;
    latch_amt   = 1'b0;
    latch_pm    = 1'b0;
    latch_chg   = 1'b0;
    latch_bal   = 1'b0;
    auth_ok     = 1'b0;
    auth_fail   = 1'b0;
    clr_lock    = 1'b0;
    case (state_q)
      S_INPUT: begin
        if (exit) clr_lock = 1'b1;
        else if (start && !locked) begin
          latch_start = 1'b1;
          nxt         = S_VALIDATE;
        end
      end
      S_VALIDATE: begin
        if (exit) nxt = S_INPUT;
        else if (lookup_ack) begin
          if (lookup_found && lookup_hash == hash_q) begin
            auth_ok = 1'b1;
            nxt     = S_BILL;
          end else begin
            auth_fail = 1'b1;
            err_fire  = 1'b1;
            err_val   = E_BAD_AUTH;
            nxt       = S_INPUT;
          end
        end else if (expired) begin
          err_fire = 1'b1;
          err_val  = E_TIMEOUT;
          nxt      = S_INPUT;
        end
      end
      S_BILL: begin
        if (exit) nxt = S_INPUT;
        else if (amount_valid) begin
          if (amount == '0 || amount > bill_amount) begin
            err_fire = 1'b1;
            err_val  = E_BAD_AMOUNT;
          end else begin
            latch_amt = 1'b1;
            nxt       = S_METHOD;
          end
        end
      end
      S_METHOD: begin
        if (exit) nxt = S_INPUT;
        else if (method_valid) begin
          latch_pm = 1'b1;
          nxt      = S_CHARGES;
        end
      end
      S_CHARGES: begin
        if (exit) nxt = S_INPUT;
        else if (total[AMT_W]) begin
          err_fire = 1'b1;
          err_val  = E_OVERFLOW;
          nxt      = S_BILL;
        end else begin
          latch_chg = 1'b1;
          nxt       = S_OLDBAL;
        end
      end
      S_OLDBAL: begin
        if (exit) nxt = S_INPUT;
        else begin
          latch_bal = 1'b1;
          nxt       = S_TXN;
        end
      end
      S_TXN: begin
        // Debit is atomic once requested: exit is not honoured here
        if (txn_ack) begin
          if (txn_ok) nxt = S_RECEIPT;
          else begin
            err_fire = 1'b1;
            err_val  = E_TXN_FAIL;
            nxt      = S_INPUT;
          end
        end else if (expired) begin
          err_fire = 1'b1;
          err_val  = E_TIMEOUT;
          nxt      = S_INPUT;
        end
      end
      S_RECEIPT: nxt = S_INPUT;
      default:   nxt = S_INPUT;
    endcase
  end

  // Session datapath: latched ids, amounts, charges, balance and error report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phone_q     <= '0;
      hash_q      <= '0;
      amt_q       <= '0;
      pm_q        <= 1'b0;
      bill_amount <= '0;
      charges     <= '0;
      txn_amount  <= '0;
      new_balance <= '0;
      error       <= 1'b0;
      err_code    <= E_NONE;
    end else begin
      error <= err_fire;
      if (err_fire) err_code <= err_val;
      if (latch_start) begin
        phone_q     <= phone_number;
        hash_q      <= auth_hash;
        err_code    <= E_NONE;
        bill_amount <= '0;
        charges     <= '0;
        txn_amount  <= '0;
        new_balance <= '0;
      end
      if (auth_ok)   bill_amount <= lookup_bill;
      if (latch_amt) amt_q       <= amount;
      if (latch_pm)  pm_q        <= pay_method;
      if (latch_chg) begin
        charges    <= pm_q ? CHEQUE_FEE : '0;
        txn_amount <= total[AMT_W-1:0];
      end
      if (latch_bal) new_balance <= bill_amount - amt_q;
    end
  end

  // Consecutive auth failures; lockout cleared only by exit while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt <= '0;
      locked   <= 1'b0;
    end else if (clr_lock) begin
      fail_cnt <= '0;
      locked   <= 1'b0;
    end else if (auth_ok) begin
      fail_cnt <= '0;
    end else if (auth_fail) begin
      if (fail_cnt != 3'd7) fail_cnt <= fail_inc;
      if (fail_inc >= 3'(MAX_RETRIES)) locked <= 1'b1;
    end
  end

  assign state         = state_q;
  assign lookup_req    = (state_q == S_VALIDATE);
  assign txn_req       = (state_q == S_TXN);
  assign receipt_valid = (state_q == S_RECEIPT);

endmodule

// File: tb/tb_atp_session_ctrl.sv
// Directed bench for atp_session_ctrl: happy path, cheque fee, overflow,
// auth lockout, bad amounts, timeout, ledger failure, exit and reset.
module tb_atp_session_ctrl;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0, exit = 0;
  logic [11:0] phone_number = 12'h123;
  logic [7:0]  auth_hash = 8'hED;
  logic        lookup_req;
  logic        lookup_ack = 0, lookup_found = 0;
  logic [7:0]  lookup_hash = 0;
  logic [10:0] lookup_bill = 0;
  logic [10:0] amount = 0;
  logic        amount_valid = 0;
  logic        pay_method = 0, method_valid = 0;
  logic [10:0] charges;
  logic        txn_req;
  logic [10:0] txn_amount;
  logic        txn_ack = 0, txn_ok = 0;
  logic [10:0] bill_amount, new_balance;
  logic        receipt_valid, error, locked;
  logic [2:0]  err_code, state;

  int n_chk = 0;
  int n_err = 0;

  atp_session_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .exit(exit),
    .phone_number(phone_number), .auth_hash(auth_hash),
    .lookup_req(lookup_req), .lookup_ack(lookup_ack),
    .lookup_found(lookup_found), .lookup_hash(lookup_hash),
    .lookup_bill(lookup_bill), .amount(amount), .amount_valid(amount_valid),
    .pay_method(pay_method), .method_valid(method_valid), .charges(charges),
    .txn_req(txn_req), .txn_amount(txn_amount), .txn_ack(txn_ack),
    .txn_ok(txn_ok), .bill_amount(bill_amount), .new_balance(new_balance),
    .receipt_valid(receipt_valid), .error(error), .err_code(err_code),
    .state(state), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] h);
    auth_hash = h; start = 1; tick(); start = 0;
  endtask

  task automatic do_lookup(input logic f, input logic [7:0] h, input logic [10:0] b);
    lookup_ack = 1; lookup_found = f; lookup_hash = h; lookup_bill = b;
    tick();
    lookup_ack = 0;
  endtask

  // Runs a session from idle up to the first cycle of TRANSACTION
  task automatic go_txn(input logic [10:0] b, input logic [10:0] a, input logic m);
    do_start(8'hED);
    do_lookup(1, 8'hED, b);
    amount = a; amount_valid = 1; tick(); amount_valid = 0;
    pay_method = m; method_valid = 1; tick(); method_valid = 0;
    tick();
    tick();
  endtask

  initial begin
    repeat (2) tick();
    // reset state
    chk("rst_state", state, 0);
    chk("rst_lreq", lookup_req, 0);
    chk("rst_treq", txn_req, 0);
    chk("rst_err", {error, err_code}, 0);
    chk("rst_locked", locked, 0);
    chk("rst_txnamt", txn_amount, 0);
    rst = 0;
    tick();

    // valid cash payment, acks after 2 cycles
    do_start(8'hED);
    chk("v_state_val", state, 1);
    chk("v_lreq", lookup_req, 1);
    tick();
    chk("v_wait", state, 1);
    do_lookup(1, 8'hED, 11'd300);
    chk("v_state_bill", state, 2);
    chk("v_lreq_drop", lookup_req, 0);
    chk("v_bill", bill_amount, 300);
    amount = 11'd100; amount_valid = 1; tick(); amount_valid = 0;
    chk("v_state_meth", state, 4);
    pay_method = 0; method_valid = 1; tick(); method_valid = 0;
    chk("v_state_chg", state, 3);
    tick();
    chk("v_state_old", state, 5);
    chk("v_charges", charges, 0);
    chk("v_txnamt", txn_amount, 100);
    tick();
    chk("v_state_txn", state, 6);
    chk("v_newbal", new_balance, 200);
    chk("v_treq", txn_req, 1);
    tick();
    chk("v_txn_wait", state, 6);
    txn_ack = 1; txn_ok = 1; tick(); txn_ack = 0;
    chk("v_receipt", receipt_valid, 1);
    chk("v_treq_drop", txn_req, 0);
    tick();
    chk("v_receipt_pulse", receipt_valid, 0);
    chk("v_idle", state, 0);
    chk("v_hold_txnamt", txn_amount, 100);
    chk("v_no_err", error, 0);

    // cheque payment
    go_txn(11'd300, 11'd100, 1);
    chk("c_state_txn", state, 6);
    chk("c_charges", charges, 10);
    chk("c_txnamt", txn_amount, 110);
    chk("c_newbal", new_balance, 200);
    txn_ack = 1; txn_ok = 1; tick(); txn_ack = 0;
    chk("c_receipt", receipt_valid, 1);
    tick();

    // overflow: 2040 + 10 > 2047
    do_start(8'hED);
    do_lookup(1, 8'hED, 11'd2047);
    amount = 11'd2040; amount_valid = 1; tick(); amount_valid = 0;
    pay_method = 1; method_valid = 1; tick(); method_valid = 0;
    chk("o_state_chg", state, 3);
    tick();
    chk("o_state_bill", state, 2);
    chk("o_err", {error, err_code}, {1'b1, 3'd3});
    tick();
    chk("o_err_pulse", error, 0);
    exit = 1; tick(); exit = 0;
    chk("o_exit_idle", state, 0);
    chk("o_exit_noerr", error, 0);
    chk("o_code_held", err_code, 3);

    // three auth failures then lockout
    for (int i = 0; i < 3; i++) begin
      do_start(8'h96);
      chk("a_clr_code", err_code, 0);
      do_lookup(1, 8'hED, 11'd300);
      chk("a_state", state, 0);
      chk("a_err", {error, err_code}, {1'b1, 3'd1});
      chk("a_locked", locked, (i == 2) ? 1 : 0);
    end
    start = 1; tick(); start = 0;
    chk("a_start_ignored", state, 0);
    chk("a_still_locked", locked, 1);
    exit = 1; tick(); exit = 0;
    chk("a_unlock", locked, 0);

    // bad amounts on bill 300
    do_start(8'hED);
    do_lookup(1, 8'hED, 11'd300);
    amount = 11'd0; amount_valid = 1; tick();
    chk("b_zero_state", state, 2);
    chk("b_zero_err", {error, err_code}, {1'b1, 3'd2});
    amount = 11'd301; tick(); amount_valid = 0;
    chk("b_big_state", state, 2);
    chk("b_big_err", {error, err_code}, {1'b1, 3'd2});
    exit = 1; tick(); exit = 0;
    chk("b_exit_idle", state, 0);
    chk("b_exit_noerr", error, 0);

    // lookup timeout after 255 waiting cycles
    do_start(8'hED);
    repeat (254) tick();
    chk("t_last_wait", {state, lookup_req}, {3'd1, 1'b1});
    tick();
    chk("t_state", state, 0);
    chk("t_err", {error, err_code}, {1'b1, 3'd5});
    chk("t_lreq", lookup_req, 0);
    chk("t_not_auth", locked, 0);

    // ledger rejects debit
    go_txn(11'd300, 11'd50, 0);
    txn_ack = 1; txn_ok = 0; tick(); txn_ack = 0;
    chk("f_state", state, 0);
    chk("f_err", {error, err_code}, {1'b1, 3'd4});

    // exit ignored in TRANSACTION, then async reset mid-debit
    go_txn(11'd300, 11'd100, 1);
    exit = 1; tick(); exit = 0;
    chk("x_ignored", {state, txn_req}, {3'd6, 1'b1});
    rst = 1; #1;
    chk("r_state", state, 0);
    chk("r_treq", txn_req, 0);
    chk("r_outs", {txn_amount, charges, new_balance}, 0);
    chk("r_bill", bill_amount, 0);
    tick();
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
